// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the flappy-bird game-phase sequencer.
// Holds the phase encoding and the default divisor constants.
package game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DEAD  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int DIV_W_DEF          = 26;
    localparam int BIRD_DIV_DEF       = 200000;
    localparam int PIPE_DIV_START_DEF = 400000;
    localparam int PIPE_DIV_STEP_DEF  = 25000;
    localparam int PIPE_DIV_MIN_DEF   = 150000;
    localparam int LEVEL_EVERY_DEF    = 5;
    localparam int DEATH_TICKS_DEF    = 50000000;

    localparam logic [3:0] LEVEL_MAX  = 4'd15;

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Period counter producing a one-cycle tick every i_period enabled cycles.
// Ports: i_clk, i_clr (async reset), i_en (count enable), i_clear
// (restart from 0 and load period), i_period (cycles per tick), o_tick.
module tick_divider #(
    parameter int DIV_W = 26
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_period,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_period;

    // Compare against the period captured at the last wrap so a period
    // change never truncates or stretches the interval in progress.
    assign o_tick = i_en && (r_cnt == r_period - DIV_W'(1));

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_cnt    <= '0;
            r_period <= '0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_period <= i_period;
        end else if (i_en) begin
            if (o_tick) begin
                r_cnt    <= '0;
                r_period <= i_period;
            end else begin
                r_cnt    <= r_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game-phase controller: READY/PLAY/DEAD/OVER sequencing, bird and pipe
// update strobes, score-driven speed level and the position reload pulse.
// Ports: i_clk, i_clr (async reset), i_jump, i_collide, i_score_inc in;
// o_run, o_bird_tick, o_pipe_tick, o_reload, o_state[2], o_level[4] out.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int BIRD_DIV       = BIRD_DIV_DEF,
    parameter int PIPE_DIV_START = PIPE_DIV_START_DEF,
    parameter int PIPE_DIV_STEP  = PIPE_DIV_STEP_DEF,
    parameter int PIPE_DIV_MIN   = PIPE_DIV_MIN_DEF,
    parameter int LEVEL_EVERY    = LEVEL_EVERY_DEF,
    parameter int DEATH_TICKS    = DEATH_TICKS_DEF,
    parameter int DIV_W          = DIV_W_DEF
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_jump,
    input  logic       i_collide,
    input  logic       i_score_inc,
    output logic       o_run,
    output logic       o_bird_tick,
    output logic       o_pipe_tick,
    output logic       o_reload,
    output logic [1:0] o_state,
    output logic [3:0] o_level
);

    localparam int SUB_W = (LEVEL_EVERY > 1) ? $clog2(LEVEL_EVERY) : 1;
    localparam int XW    = DIV_W + 4;

    state_e           r_state;
    state_e           w_next_state;
    logic             r_jump_q;
    logic             r_jump_armed;
    logic             w_jump_rise;
    logic [3:0]       r_level;
    logic [SUB_W-1:0] r_sub;
    logic             w_play;
    logic             w_tick_en;
    logic             w_clr_ticks;
    logic             w_clr_freeze;
    logic             w_freeze_done;
    logic             w_reload;
    logic [XW-1:0]    w_dec;
    logic [DIV_W-1:0] w_pipe_period;

    // A jump held through reset release must be let go before it counts,
    // so edges are only accepted once jump has been seen low.
    assign w_jump_rise = i_jump && !r_jump_q && r_jump_armed;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_jump_q     <= 1'b0;
            r_jump_armed <= 1'b0;
        end else begin
            r_jump_q     <= i_jump;
            r_jump_armed <= r_jump_armed | ~i_jump;
        end
    end

    assign w_play    = (r_state == ST_PLAY);
    // Collision wins over any strobe due in the same cycle.
    assign w_tick_en = w_play && !i_collide;

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clr_ticks  = 1'b0;
        w_clr_freeze = 1'b0;
        w_reload     = 1'b0;
        unique case (r_state)
            ST_READY: begin
                if (w_jump_rise) begin
                    w_next_state = ST_PLAY;
                    w_clr_ticks  = 1'b1;
                end
            end
            ST_PLAY: begin
                if (i_collide) begin
                    w_next_state = ST_DEAD;
                    w_clr_freeze = 1'b1;
                end
            end
            ST_DEAD: begin
                if (w_freeze_done) begin
                    w_next_state = ST_OVER;
                end
            end
            ST_OVER: begin
                if (w_jump_rise) begin
                    w_next_state = ST_READY;
                    w_reload     = 1'b1;
                end
            end
            default: w_next_state = ST_READY;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_level <= '0;
            r_sub   <= '0;
        end else if (w_reload) begin
            r_level <= '0;
            r_sub   <= '0;
        end else if (w_play && i_score_inc) begin
            if (r_sub == SUB_W'(LEVEL_EVERY - 1)) begin
                r_sub <= '0;
                if (r_level != LEVEL_MAX) begin
                    r_level <= r_level + 4'd1;
                end
            end else begin
                r_sub <= r_sub + SUB_W'(1);
            end
        end
    end

    // Widened so level*step cannot wrap before the floor compare.
    always_comb begin
        w_dec = XW'(PIPE_DIV_STEP) * XW'(r_level);
        if (w_dec + XW'(PIPE_DIV_MIN) >= XW'(PIPE_DIV_START)) begin
            w_pipe_period = DIV_W'(PIPE_DIV_MIN);
        end else begin
            w_pipe_period = DIV_W'(PIPE_DIV_START) - w_dec[DIV_W-1:0];
        end
    end

    tick_divider #(.DIV_W(DIV_W)) u_bird_div (
        .i_clk    (i_clk),
        .i_clr    (i_clr),
        .i_en     (w_tick_en),
        .i_clear  (w_clr_ticks),
        .i_period (DIV_W'(BIRD_DIV)),
        .o_tick   (o_bird_tick)
    );

    tick_divider #(.DIV_W(DIV_W)) u_pipe_div (
        .i_clk    (i_clk),
        .i_clr    (i_clr),
        .i_en     (w_tick_en),
        .i_clear  (w_clr_ticks),
        .i_period (w_pipe_period),
        .o_tick   (o_pipe_tick)
    );

    tick_divider #(.DIV_W(DIV_W)) u_freeze_div (
        .i_clk    (i_clk),
        .i_clr    (i_clr),
        .i_en     (r_state == ST_DEAD),
        .i_clear  (w_clr_freeze),
        .i_period (DIV_W'(DEATH_TICKS)),
        .o_tick   (w_freeze_done)
    );

    assign o_run    = w_play;
    assign o_reload = w_reload;
    assign o_state  = r_state;
    assign o_level  = r_level;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with small divisors.
// Per-cycle scoreboard against a behavioural model plus directed checks.
module tb_game_sequencer;
    import game_sequencer_pkg::*;

    localparam int BD  = 4;
    localparam int PS  = 10;
    localparam int PST = 2;
    localparam int PMN = 6;
    localparam int LE  = 2;
    localparam int DT  = 8;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       jump = 1'b0;
    logic       collide = 1'b0;
    logic       score_inc = 1'b0;
    logic       run;
    logic       bird_tick;
    logic       pipe_tick;
    logic       reload;
    logic [1:0] state;
    logic [3:0] level;

    always #5 clk = ~clk;

    game_sequencer #(
        .BIRD_DIV       (BD),
        .PIPE_DIV_START (PS),
        .PIPE_DIV_STEP  (PST),
        .PIPE_DIV_MIN   (PMN),
        .LEVEL_EVERY    (LE),
        .DEATH_TICKS    (DT),
        .DIV_W          (DIV_W_DEF)
    ) u_dut (
        .i_clk       (clk),
        .i_clr       (clr),
        .i_jump      (jump),
        .i_collide   (collide),
        .i_score_inc (score_inc),
        .o_run       (run),
        .o_bird_tick (bird_tick),
        .o_pipe_tick (pipe_tick),
        .o_reload    (reload),
        .o_state     (state),
        .o_level     (level)
    );

    int          n_pass = 0;
    int          n_chk  = 0;
    int          cyc    = 0;
    int          bt_q[$];
    int          pt_q[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  last;
    string       phase = "init";

    int m_state, m_bc, m_pc, m_pper, m_fc, m_lvl, m_sub;
    bit m_jq, m_arm;

    task automatic check(input string tag, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, want);
    endtask

    function automatic int pipe_per(input int l);
        int p;
        p = PS - l * PST;
        return (p < PMN) ? PMN : p;
    endfunction

    function automatic logic [9:0] outvec();
        return {state, run, bird_tick, pipe_tick, reload, level};
    endfunction

    function automatic logic [9:0] model_out(input bit j, input bit c);
        bit play, en, b, p, rise, rl;
        play = (m_state == 1);
        en   = play && !c;
        b    = en && (m_bc == BD - 1);
        p    = en && (m_pc == m_pper - 1);
        rise = j && !m_jq && m_arm;
        rl   = (m_state == 3) && rise;
        return {m_state[1:0], play, b, p, rl, m_lvl[3:0]};
    endfunction

    task automatic model_reset();
        m_state = 0; m_bc = 0; m_pc = 0; m_pper = 0;
        m_fc = 0; m_lvl = 0; m_sub = 0; m_jq = 0; m_arm = 0;
    endtask

    task automatic model_next(input bit j, input bit c, input bit s);
        bit en, b, p, rise;
        en   = (m_state == 1) && !c;
        b    = en && (m_bc == BD - 1);
        p    = en && (m_pc == m_pper - 1);
        rise = j && !m_jq && m_arm;
        case (m_state)
            0: if (rise) begin
                m_state = 1; m_bc = 0; m_pc = 0;
                m_pper = pipe_per(m_lvl);
            end
            1: begin
                if (c) begin
                    m_state = 2; m_fc = 0;
                end else begin
                    m_bc = b ? 0 : m_bc + 1;
                    if (p) begin
                        m_pc = 0; m_pper = pipe_per(m_lvl);
                    end else begin
                        m_pc = m_pc + 1;
                    end
                end
                if (s) begin
                    if (m_sub == LE - 1) begin
                        m_sub = 0;
                        if (m_lvl < 15) m_lvl = m_lvl + 1;
                    end else begin
                        m_sub = m_sub + 1;
                    end
                end
            end
            2: if (m_fc == DT - 1) m_state = 3; else m_fc = m_fc + 1;
            default: if (rise) begin
                m_state = 0; m_lvl = 0; m_sub = 0;
            end
        endcase
        m_jq = j;
        if (!j) m_arm = 1;
    endtask

    task automatic step(input bit j, input bit c, input bit s);
        @(negedge clk);
        jump = j; collide = c; score_inc = s;
        exp_q.push_back(model_out(j, c));
        #1;
        cyc++;
        last = outvec();
        check({phase, "/out"}, int'(last), int'(exp_q.pop_front()));
        if (last[6]) bt_q.push_back(cyc);
        if (last[5]) pt_q.push_back(cyc);
        model_next(j, c, s);
    endtask

    task automatic do_clr(input bit j);
        @(negedge clk);
        #2;
        jump = j; collide = 0; score_inc = 0;
        clr = 1'b1;
        #1;
        check("async_clr", int'(outvec()), 0);
        model_reset();
        @(negedge clk);
        #2;
        clr = 1'b0;
        model_next(j, 1'b0, 1'b0);
    endtask

    function automatic int last_gap();
        int n;
        n = pt_q.size();
        return (n >= 2) ? pt_q[n-1] - pt_q[n-2] : -1;
    endfunction

    initial begin
        int k3;
        #1;
        check("rst_out", int'(outvec()), 0);
        model_reset();
        #11;
        clr = 1'b0;
        model_next(1'b0, 1'b0, 1'b0);

        phase = "idle";
        repeat (50) step(0, 0, 0);
        check("idle_ticks", bt_q.size() + pt_q.size(), 0);

        phase = "start";
        step(1, 0, 0);
        cyc = 0; bt_q.delete(); pt_q.delete();
        step(0, 0, 0);
        check("enter_play", int'(last[9:8]), 1);
        repeat (19) step(0, 0, 0);
        for (int i = 0; i < 3; i++)
            check($sformatf("bird_t%0d", i),
                  (i < bt_q.size()) ? bt_q[i] : -1, BD * (i + 1));
        for (int i = 0; i < 2; i++)
            check($sformatf("pipe_t%0d", i),
                  (i < pt_q.size()) ? pt_q[i] : -1, PS * (i + 1));

        phase = "lvl";
        step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
        check("lvl1", int'(last[3:0]), 1);
        pt_q.delete();
        repeat (30) step(0, 0, 0);
        check("gap8", last_gap(), 8);
        repeat (6) step(0, 0, 1);
        step(0, 0, 0);
        check("lvl4", int'(last[3:0]), 4);
        pt_q.delete();
        repeat (30) step(0, 0, 0);
        check("gap6", last_gap(), 6);
        repeat (30) step(0, 0, 1);
        step(0, 0, 0);
        check("lvl15", int'(last[3:0]), 15);
        pt_q.delete();
        repeat (20) step(0, 0, 0);
        check("gap6_sat", last_gap(), 6);

        phase = "coll";
        for (int k = 0; k < 10 && m_bc != BD - 1; k++) step(0, 0, 0);
        step(0, 1, 0);
        check("coll_no_bird", int'(last[6]), 0);
        phase = "dead";
        k3 = -1;
        for (int k = 1; k <= 12; k++) begin
            step(k == 2 || k == 4, 0, k == 3 || k == 5);
            if (k == 1) begin
                check("dead_state", int'(last[9:8]), 2);
                check("dead_run", int'(last[7]), 0);
            end
            if (last[9:8] == 2'd3 && k3 < 0) k3 = k;
        end
        check("dead_len", k3, DT + 1);

        phase = "over";
        step(1, 0, 0);
        check("reload", int'(last[4]), 1);
        step(0, 0, 0);
        check("reload_1cyc", int'(last[4]), 0);
        check("over_ready", int'(last[9:8]), 0);
        check("lvl_clr", int'(last[3:0]), 0);

        phase = "game2";
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 1, 0);
        for (int k = 1; k <= 12; k++) step(0, 0, k == 2 || k == 4 || k == 6);
        check("dead_score_ign", int'(last[3:0]), 0);
        step(1, 0, 0);
        step(0, 0, 0);

        phase = "midclr";
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        do_clr(1'b0);
        step(1, 0, 0);
        cyc = 0; bt_q.delete();
        repeat (4) step(0, 0, 0);
        check("restart_bird", (bt_q.size() > 0) ? bt_q[0] : -1, BD);

        phase = "held";
        do_clr(1'b1);
        repeat (5) step(1, 0, 0);
        check("held_ready", int'(last[9:8]), 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        check("held_rearm", int'(last[9:8]), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-phase controller for the flappy-bird datapath.
- Sequences ready, play, death-freeze and game-over phases, and generates the single-cycle bird/pipe update strobes.
- Raises pipe speed as score accumulates and issues a reload pulse that re-initialises object positions.
- Sits between the debouncer, collision and score logic and the position-update block; replaces free-running tick clocks plus a raw done flag.

Parameters:
- BIRD_DIV, 200000: clk cycles between bird_tick pulses.
- PIPE_DIV_START, 400000: pipe_tick period at level 0.
- PIPE_DIV_STEP, 25000: period reduction per level.
- PIPE_DIV_MIN, 150000: floor on pipe_tick period.
- LEVEL_EVERY, 5: score_inc pulses per level increment.
- DEATH_TICKS, 50000000: freeze length in DEAD (1 s at 50 MHz).
- DIV_W, 26: width of all period counters.

Ports:
- clk, in, 1: master clock, 50 MHz.
- clr, in, 1: reset.
- jump, in, 1: debounced jump level.
- collide, in, 1: OR of overlap/ground/ceiling flags.
- score_inc, in, 1: one-cycle pulse when the bird clears a pipe.
- run, out, 1: datapath update enable; high only in PLAY.
- bird_tick, out, 1: one-cycle bird update strobe.
- pipe_tick, out, 1: one-cycle pipe update strobe.
- reload, out, 1: one-cycle pulse to re-initialise bird/pipe positions and scores.
- state, out, 2: READY=0, PLAY=1, DEAD=2, OVER=3.
- level, out, 4: current speed level.

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous and active-high.
- Reset values: state=READY; run, bird_tick, pipe_tick and reload all 0; level=0. Internal counters, jump_q and the score sub-counter all reset to 0.
- Jump edge: jump_rise = jump & ~jump_q, with jump_q registered every cycle. If jump is held through reset release, no edge occurs until it is released and pressed again.

FSM transitions (registered; outputs decoded from state):
- READY -> PLAY on jump_rise. On this edge, clear both period counters.
- PLAY -> DEAD when collide=1. Collision has priority: no tick strobe is issued in the cycle collide is sampled high.
- DEAD -> OVER when the freeze counter reaches DEATH_TICKS-1. The freeze counter is cleared on entry to DEAD.
- OVER -> READY on jump_rise. In the same cycle: reload=1, level cleared to 0, score sub-counter cleared. reload is high for exactly one cycle.
- jump_rise in PLAY or DEAD has no effect on state. The datapath handles the jump itself.

Tick generation (PLAY only; counters hold in other states):
- bird counter increments each cycle. At BIRD_DIV-1 it asserts bird_tick and wraps to 0. The first bird_tick occurs exactly BIRD_DIV cycles after the PLAY entry edge.
- pipe counter works the same way against pipe_period. pipe_period = max(PIPE_DIV_START - level*PIPE_DIV_STEP, PIPE_DIV_MIN), computed in DIV_W bits with no underflow.
- A level change takes effect at the next pipe counter wrap. The compare uses the period latched at the last wrap.
- bird_tick and pipe_tick may coincide.

Level:
- score_inc is counted only in PLAY; it is ignored in other states.
- When the sub-counter reaches LEVEL_EVERY-1 and score_inc=1, the sub-counter wraps to 0 and level increments.
- level saturates at 15.

Reset mid-operation:
- clr in any state returns to READY immediately with all outputs low.
- reload is not asserted by clr; the datapath resets on clr itself.

Decomposition:
- Shared package holds:
  - state encoding constants READY/PLAY/DEAD/OVER;
  - default divisor constants, so the top level and the testbench agree.
- One natural sub-module: tick_divider.
  - Inputs: clk, clr, en, clear, period[DIV_W].
  - Output: tick.
  - Latches period at each wrap.
  - Instantiated twice (bird and pipe); a third instance, with constant period and en = (state==DEAD), serves as the freeze timer.

Test Plan:
All scenarios use BIRD_DIV=4, PIPE_DIV_START=10, PIPE_DIV_STEP=2, PIPE_DIV_MIN=6, LEVEL_EVERY=2, DEATH_TICKS=8.
- Reset then idle 50 cycles -> state=0, run=0, no ticks. Jump pulse -> state=1 next cycle; bird_tick at cycles 4, 8, 12 and pipe_tick at 10, 20 after entry.
- In PLAY, 2 score_inc pulses -> level=1; pipe interval becomes 8 after the next wrap. 6 more pulses -> level=4, period clamps at 6; further pulses saturate level at 15, period stays 6.
- collide asserted on the same cycle a bird_tick is due -> no bird_tick; state=2 next cycle; run=0. Exactly 8 cycles later state=3.
- In DEAD, jump pulses and score_inc pulses -> ignored, level unchanged. In OVER, jump -> one-cycle reload, state=0, level=0.
- jump held high across clr release -> stays READY until jump falls and rises again.
- clr asserted mid-PLAY between ticks -> outputs low asynchronously, state=0. Next jump restarts with the first bird_tick exactly 4 cycles later.
